// File: rtl/axi_slave_mem_if.sv
// AXI3 bus bundle between the master agent and the slave memory responder.
// The slave modport is what the memory endpoint plugs into.
interface axi_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI3 slave memory: one outstanding write and one outstanding read, independent
// channels, FIXED/INCR/WRAP bursts up to 16 beats, byte strobes, OKAY/SLVERR.
module axi_slave_mem #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 1024
) (
    input  logic aclk,
    input  logic arst,
    axi_slave_mem_if.slave bus
);
    localparam int         IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return |a[ADDR_W-1:IDX_W+2];
    endfunction

    function automatic logic illegal_burst(input logic [ADDR_W-1:0] a, input logic [3:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] incr;
        logic              wrap_len_ok;
        incr        = ADDR_W'(1) << size;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (size > 3'd2) || (burst == 2'b11) ||
               ((burst == 2'b10) && (!wrap_len_ok || ((a & (incr - 1'b1)) != '0)));
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [3:0] len,
                                                    input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] bnd;
        incr = ADDR_W'(1) << size;
        bnd  = (ADDR_W'(len) + 1'b1) << size;
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~(bnd - 1'b1)) | ((a + incr) & (bnd - 1'b1));
            default: return a + incr;
        endcase
    endfunction

    // ---------------- write channel ----------------
    w_state_t          w_state_q, w_state_d;
    logic              awready_q, wready_q, bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [3:0]        wlen_q, wcnt_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic              willegal_q, werr_q;

    logic aw_fire, w_fire, b_fire, w_last_beat, w_beat_err, w_mem_we;
    assign aw_fire     = awready_q && bus.awvalid;
    assign w_fire      = wready_q && bus.wvalid;
    assign b_fire      = bvalid_q && bus.bready;
    assign w_last_beat = (wcnt_q == wlen_q);
    assign w_beat_err  = (bus.wid != bid_q) || (bus.wlast != w_last_beat) || out_of_range(waddr_q);
    assign w_mem_we    = w_fire && !willegal_q && !out_of_range(waddr_q);

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_fire) w_state_d = W_DATA;
            W_DATA:  if (w_fire && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (b_fire) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state so none are combinational.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wcnt_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            willegal_q <= 1'b0;
            werr_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE);
            wready_q  <= (w_state_d == W_DATA);
            bvalid_q  <= (w_state_d == W_RESP);
            if (aw_fire) begin
                bid_q      <= bus.awid;
                waddr_q    <= bus.awaddr;
                wlen_q     <= bus.awlen;
                wsize_q    <= bus.awsize;
                wburst_q   <= bus.awburst;
                wcnt_q     <= '0;
                willegal_q <= illegal_burst(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
                werr_q     <= illegal_burst(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
            end
            if (w_fire) begin
                waddr_q <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                wcnt_q  <= wcnt_q + 4'd1;
                if (w_beat_err) werr_q <= 1'b1;
                if (w_last_beat) bresp_q <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (bus.wstrb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t          r_state_q, r_state_d;
    logic              arready_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic [ADDR_W-1:0] raddr_q, r_next, rd_addr;
    logic [3:0]        rlen_q, rcnt_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q;
    logic              rillegal_q, rd_bad;

    logic ar_fire, r_fire, r_advance;
    assign ar_fire   = arready_q && bus.arvalid;
    assign r_fire    = rvalid_q && bus.rready;
    assign r_advance = r_fire && !rlast_q;
    assign r_next    = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);

    always_comb begin
        rd_addr = r_next;
        rd_bad  = rillegal_q || out_of_range(r_next);
        if (ar_fire) begin
            rd_addr = bus.araddr;
            rd_bad  = illegal_burst(bus.araddr, bus.arlen, bus.arsize, bus.arburst) ||
                      out_of_range(bus.araddr);
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_fire) r_state_d = R_DATA;
            R_DATA:  if (r_fire && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // rdata/rresp/rlast only move on AR accept or a non-last R handshake, so they hold under backpressure.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            rillegal_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_DATA);
            if (ar_fire || r_advance) begin
                rdata_q <= rd_bad ? '0 : mem[word_idx(rd_addr)];
                rresp_q <= rd_bad ? RESP_SLVERR : RESP_OKAY;
            end
            if (ar_fire) begin
                rid_q      <= bus.arid;
                raddr_q    <= bus.araddr;
                rlen_q     <= bus.arlen;
                rsize_q    <= bus.arsize;
                rburst_q   <= bus.arburst;
                rcnt_q     <= '0;
                rillegal_q <= illegal_burst(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
                rlast_q    <= (bus.arlen == 4'd0);
            end else if (r_advance) begin
                raddr_q <= r_next;
                rcnt_q  <= rcnt_q + 4'd1;
                rlast_q <= ((rcnt_q + 4'd1) == rlen_q);
            end else if (r_fire) begin
                rlast_q <= 1'b0;
            end
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    logic unused_attr;
    assign unused_attr = ^{bus.awlock, bus.awcache, bus.awprot, bus.arlock, bus.arcache, bus.arprot};
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem: bursts, strobes, errors,
// backpressure and mid-burst reset, checked with immediate assertions.
module tb_axi_slave_mem;
    logic aclk;
    logic arst;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];
    logic [1:0]  rr [16];
    logic        rl [16];
    logic [3:0]  rid_got;
    logic [3:0]  bid_got;
    logic [1:0]  bresp_got;

    axi_slave_mem_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    axi_slave_mem #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_DEPTH(1024)) dut (
        .aclk (aclk),
        .arst (arst),
        .bus  (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int last_at,
                               input int b_hold);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 50) begin tick(); n++; end
        check("aw_ready_wait", {31'd0, bus.awready}, 32'd1);
        tick();
        bus.awvalid = 1'b0;
        check("aw_wready_up", {31'd0, bus.wready}, 32'd1);
        check("aw_awready_dn", {31'd0, bus.awready}, 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            bus.wid = id; bus.wdata = wd[i]; bus.wstrb = ws[i];
            bus.wlast = (i == last_at); bus.wvalid = 1'b1;
            n = 0;
            while (bus.wready !== 1'b1 && n < 50) begin tick(); n++; end
            check("w_ready_wait", {31'd0, bus.wready}, 32'd1);
            tick();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        check("b_valid_up", {31'd0, bus.bvalid}, 32'd1);
        for (int k = 0; k < b_hold; k++) begin
            check("b_hold_valid", {31'd0, bus.bvalid}, 32'd1);
            check("b_hold_id", {28'd0, bus.bid}, {28'd0, id});
            check("b_hold_awready", {31'd0, bus.awready}, 32'd0);
            tick();
        end
        bid_got = bus.bid; bresp_got = bus.bresp;
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("b_valid_dn", {31'd0, bus.bvalid}, 32'd0);
        check("b_awready_back", {31'd0, bus.awready}, 32'd1);
        $display("write id=%0h addr=0x%08h len=%0d burst=%0d bresp=%0d", id, addr, len, burst, bresp_got);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        int n;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 50) begin tick(); n++; end
        check("ar_ready_wait", {31'd0, bus.arready}, 32'd1);
        tick();
        bus.arvalid = 1'b0;
        check("ar_rvalid_up", {31'd0, bus.rvalid}, 32'd1);
        bus.rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (bus.rvalid !== 1'b1 && n < 50) begin tick(); n++; end
            check("r_valid_wait", {31'd0, bus.rvalid}, 32'd1);
            rd[i] = bus.rdata; rr[i] = bus.rresp; rl[i] = bus.rlast; rid_got = bus.rid;
            tick();
        end
        bus.rready = 1'b0;
        check("r_valid_dn", {31'd0, bus.rvalid}, 32'd0);
        $display("read  id=%0h addr=0x%08h len=%0d burst=%0d rdata0=0x%08h", id, addr, len, burst, rd[0]);
    endtask

    initial begin
        logic [31:0] exp4 [4];
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        arst = 1'b0;
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end

        // Reset state
        repeat (3) tick();
        check("rst_awready", {31'd0, bus.awready}, 32'd0);
        check("rst_wready", {31'd0, bus.wready}, 32'd0);
        check("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
        check("rst_arready", {31'd0, bus.arready}, 32'd0);
        check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("rst_rlast", {31'd0, bus.rlast}, 32'd0);
        check("rst_bid_bresp", {26'd0, bus.bid, bus.bresp}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_rid_rresp", {26'd0, bus.rid, bus.rresp}, 32'd0);
        arst = 1'b1;
        check("rel_awready_pre", {31'd0, bus.awready}, 32'd0);
        tick();
        check("rel_awready", {31'd0, bus.awready}, 32'd1);
        check("rel_arready", {31'd0, bus.arready}, 32'd1);

        // INCR write 0x10 and read back
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        write_burst(4'h3, 32'h10, 4'd3, 3'd2, 2'b01, 3, 0);
        check("incr_bresp", {30'd0, bresp_got}, 32'd0);
        check("incr_bid", {28'd0, bid_got}, 32'h3);
        read_burst(4'h5, 32'h10, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_rdata%0d", i), rd[i], 32'(i + 1));
            check($sformatf("incr_rresp%0d", i), {30'd0, rr[i]}, 32'd0);
            check($sformatf("incr_rlast%0d", i), {31'd0, rl[i]}, (i == 3) ? 32'd1 : 32'd0);
        end
        check("incr_rid", {28'd0, rid_got}, 32'h5);

        // WRAP write at 0x38 lands at 0x38,0x3C,0x30,0x34
        write_burst(4'h1, 32'h38, 4'd3, 3'd2, 2'b10, 3, 0);
        check("wrap_bresp", {30'd0, bresp_got}, 32'd0);
        read_burst(4'h1, 32'h30, 4'd3, 3'd2, 2'b01);
        exp4[0] = 32'd3; exp4[1] = 32'd4; exp4[2] = 32'd1; exp4[3] = 32'd2;
        for (int i = 0; i < 4; i++) check($sformatf("wrap_rdata%0d", i), rd[i], exp4[i]);

        // Strobes: clear word 0, then write lanes 0 and 2 only
        wd[0] = 32'h0; ws[0] = 4'hF;
        write_burst(4'h2, 32'h0, 4'd0, 3'd2, 2'b01, 0, 0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        write_burst(4'h2, 32'h0, 4'd0, 3'd2, 2'b01, 0, 0);
        ws[0] = 4'hF;
        read_burst(4'h2, 32'h0, 4'd0, 3'd2, 2'b01);
        check("strobe_rdata", rd[0], 32'h00BB00DD);

        // FIXED burst keeps the last beat
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 5);
        write_burst(4'h4, 32'h40, 4'd3, 3'd2, 2'b00, 3, 0);
        check("fixed_bresp", {30'd0, bresp_got}, 32'd0);
        read_burst(4'h4, 32'h40, 4'd0, 3'd2, 2'b01);
        check("fixed_rdata", rd[0], 32'd8);

        // Illegal size: SLVERR, memory unchanged
        wd[0] = 32'hDEADBEEF;
        write_burst(4'h6, 32'h10, 4'd0, 3'd3, 2'b01, 0, 0);
        check("size3_bresp", {30'd0, bresp_got}, 32'h2);
        read_burst(4'h6, 32'h10, 4'd0, 3'd2, 2'b01);
        check("size3_mem_kept", rd[0], 32'd1);

        // Out-of-range read and illegal burst type read
        read_burst(4'h7, 32'h1000, 4'd0, 3'd2, 2'b01);
        check("oor_rdata", rd[0], 32'd0);
        check("oor_rresp", {30'd0, rr[0]}, 32'h2);
        check("oor_rlast", {31'd0, rl[0]}, 32'd1);
        read_burst(4'h7, 32'h10, 4'd1, 3'd2, 2'b11);
        check("badburst_rdata0", rd[0], 32'd0);
        check("badburst_rresp1", {30'd0, rr[1]}, 32'h2);

        // Early wlast on beat 2: all 4 beats taken, SLVERR, data still written
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 9);
        write_burst(4'h8, 32'h50, 4'd3, 3'd2, 2'b01, 1, 0);
        check("early_wlast_bresp", {30'd0, bresp_got}, 32'h2);
        read_burst(4'h8, 32'h50, 4'd3, 3'd2, 2'b01);
        check("early_wlast_beat4", rd[3], 32'd12);

        // B backpressure for 5 cycles
        wd[0] = 32'h12345678;
        write_burst(4'h9, 32'h80, 4'd0, 3'd2, 2'b01, 0, 5);
        check("bp_bid", {28'd0, bid_got}, 32'h9);

        // R backpressure: rready toggled, each beat held then taken once
        bus.arid = 4'hA; bus.araddr = 32'h10; bus.arlen = 4'd3; bus.arsize = 3'd2; bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rready = 1'b0;
            check($sformatf("rbp_data_a%0d", i), bus.rdata, 32'(i + 1));
            tick();
            check($sformatf("rbp_valid%0d", i), {31'd0, bus.rvalid}, 32'd1);
            check($sformatf("rbp_data_b%0d", i), bus.rdata, 32'(i + 1));
            check($sformatf("rbp_last%0d", i), {31'd0, bus.rlast}, (i == 3) ? 32'd1 : 32'd0);
            bus.rready = 1'b1;
            tick();
        end
        bus.rready = 1'b0;
        check("rbp_done", {31'd0, bus.rvalid}, 32'd0);
        $display("read  id=a addr=0x00000010 len=3 burst=1 with rready toggling");

        // Reset during beat 2 of a write
        bus.awid = 4'hB; bus.awaddr = 32'h60; bus.awlen = 4'd3; bus.awsize = 3'd2; bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wid = 4'hB; bus.wdata = 32'hAAAA0000; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wdata = 32'hAAAA0001;
        #2;
        arst = 1'b0;
        #1;
        check("midrst_wready", {31'd0, bus.wready}, 32'd0);
        check("midrst_awready", {31'd0, bus.awready}, 32'd0);
        check("midrst_bvalid", {31'd0, bus.bvalid}, 32'd0);
        check("midrst_arready", {31'd0, bus.arready}, 32'd0);
        bus.wvalid = 1'b0;
        tick();
        arst = 1'b1;
        tick();
        check("midrst_awready_back", {31'd0, bus.awready}, 32'd1);
        $display("reset asserted mid-burst id=b addr=0x00000060");
        wd[0] = 32'h66; wd[1] = 32'h77;
        write_burst(4'hC, 32'h60, 4'd1, 3'd2, 2'b01, 1, 0);
        check("postrst_bresp", {30'd0, bresp_got}, 32'd0);
        read_burst(4'hC, 32'h60, 4'd1, 3'd2, 2'b01);
        check("postrst_rdata0", rd[0], 32'h66);
        check("postrst_rdata1", rd[1], 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI3 slave memory responder: the RTL endpoint that sits directly downstream of the verification slave-side interface and is driven by the AXI master agent through it. It accepts write and read bursts (FIXED/INCR/WRAP, up to 16 beats), stores data in an internal word-addressed array with byte strobes, and returns B and R responses with OKAY/SLVERR. It supports one outstanding write and one outstanding read; the write and read channels run independently and concurrently.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32, 4 byte lanes
- ID_W, 4, transaction ID width
- MEM_DEPTH, 1024, number of DATA_W-bit words; power of two
- aclk  input  1  clock; all logic is on the rising edge
- arst  input  1  reset; one clock domain, asynchronous assertion, active-low
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  input  ID_W/ADDR_W/4/3/2/2/4/3/1  write address channel
- awready  output  1  write address accept
- wid/wdata/wstrb/wlast/wvalid  input  ID_W/DATA_W/4/1/1  write data channel
- wready  output  1  write data accept
- bid/bresp/bvalid  output  ID_W/2/1  write response
- bready  input  1  response accept
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  input  same widths as AW  read address channel
- arready  output  1  read address accept
- rid/rdata/rresp/rlast/rvalid  output  ID_W/DATA_W/2/1/1  read data channel
- rready  input  1  read data accept

## Operation
- Reset (arst=0): awready, wready, bvalid, arready, rvalid and rlast are 0; bid, bresp, rid, rdata and rresp are 0. Memory contents are not reset. Assertion mid-burst abandons the burst immediately.
- The following inputs are ignored: awlock, arlock, awcache, arcache, awprot, arprot.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, capture id, addr, len, size and burst. Compute the error flag, then go to W_DATA.
  - W_DATA: wready=1. On each W handshake:
    - write the byte lanes whose wstrb bit is 1 at word index addr[log2(MEM_DEPTH)+1:2];
    - advance addr and the beat counter.
    - The beat where counter==len is the last beat; go to W_RESP.
  - W_RESP: bvalid=1, bid is the captured awid, bresp=OKAY(00) or SLVERR(10). On B handshake, go to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, capture the fields and load rdata from the start address; go to R_DATA.
  - R_DATA: rvalid=1; rid is the captured arid; rlast=1 when counter==len. rdata, rresp and rlast are held stable while rvalid=1 and rready=0.
  - On a non-last R handshake, rdata is reloaded from the next address.
  - On the last R handshake, go to R_IDLE.
- Address advance, with incr = 1<<size:
  - FIXED(00): address unchanged.
  - INCR(01): addr + incr. Wraps modulo 2^ADDR_W; no 4KB check.
  - WRAP(10): boundary = (len+1)*incr; next = (addr & ~(boundary-1)) | ((addr+incr) & (boundary-1)).
- SLVERR conditions, evaluated per burst:
  - size>2;
  - burst=11;
  - WRAP with len not in {1,3,7,15};
  - WRAP with start address not aligned to incr;
  - any beat with word index >= MEM_DEPTH (upper address bits nonzero);
  - for writes only: wid != awid on any beat, or a wlast value that disagrees with the last-beat rule on any beat.
- Error handling:
  - Illegal size/burst/wrap: no memory writes occur for the whole burst, and reads return rdata=0 with rresp=SLVERR on every beat.
  - Out-of-range beat: that beat alone is suppressed (write) or returns 0 (read). bresp is SLVERR for the burst; rresp is SLVERR on that beat only.
- The burst length is always len+1 beats regardless of wlast; an early or missing wlast only sets SLVERR.

## Timing
- awready and arready rise on the first rising edge after arst deasserts.
- AW handshake at edge N: awready=0 and wready=1 from N.
- Last W handshake at edge M: wready=0 and bvalid=1 from M. No write-path outputs are combinational.
- B handshake at edge K: awready=1 from K. Minimum write turnaround is one idle cycle between bursts.
- AR handshake at edge N: rvalid=1 with the first beat's rdata from N.
- Throughput is one beat per cycle on both W and R when valid/ready are held high.
- Concurrent write and read to the same word at the same edge: the read register captures the old data.

## Test plan
- INCR write, awaddr=0x10, len=3, size=2, wstrb=F, data 1..4, then INCR read of the same burst -> bresp=00; rdata 1,2,3,4; rlast only on beat 4; rresp=00.
- WRAP write, awaddr=0x38, len=3, size=2 -> words written at 0x38, 0x3C, 0x30, 0x34. Reading back at 0x30 INCR returns beats 3, 4, 1, 2.
- Narrow/strobe: write 0xAABBCCDD with wstrb=0101 over 0x00000000 -> readback 0x00BB00DD. A FIXED len=3 write leaves only the last beat's data.
- Errors:
  - awsize=3 -> bresp=10, memory unchanged;
  - araddr=MEM_DEPTH*4 -> rdata=0, rresp=10;
  - early wlast on beat 2 of 4 -> 4 beats accepted, bresp=10.
- Backpressure: bready held 0 for 5 cycles -> bvalid and bid stay stable and awready=0. rready toggled -> rdata and rlast stay stable, with no beat skipped or duplicated.
- Reset mid-burst: arst=0 during beat 2 of a write -> all outputs are 0 immediately. After release, a new burst completes with bresp=00.
